// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader_if
// Description : Word-stream, memory write bus and status bundle for the
//               instruction memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       word_in;
  logic              word_valid;
  logic              word_last;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic [CNT_W-1:0]  words_loaded;
  logic              load_done;
  logic              overflow;

  modport master (
    output start, base_addr, word_in, word_valid, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata,
    input  busy, words_loaded, load_done, overflow
  );

  modport slave (
    input  start, base_addr, word_in, word_valid, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata,
    output busy, words_loaded, load_done, overflow
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Splits 32-bit instruction words into four big-endian byte
//               writes to a byte-wide instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = 7
) (
  input wire                  clk,
  input wire                  reset_n,
  instr_mem_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_word_step = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_align     = ~ADDR_W'(3);
  localparam logic [CNT_W-1:0]  c_max_words = CNT_W'(MAX_WORDS);

  state_t            r_state,     w_state;
  logic [ADDR_W-1:0] r_word_addr, w_word_addr;
  logic [31:0]       r_word,      w_word;
  logic              r_last,      w_last;
  logic [1:0]        r_byte_idx,  w_byte_idx;
  logic [CNT_W-1:0]  r_cnt,       w_cnt;
  logic              r_ovf,       w_ovf;
  logic              r_ready,     w_ready;
  logic              r_we,        w_we;
  logic [ADDR_W-1:0] r_addr,      w_addr;
  logic [7:0]        r_wdata,     w_wdata;
  logic              r_busy,      w_busy;
  logic              r_done,      w_done;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_word_addr <= '0;
      r_word      <= '0;
      r_last      <= 1'b0;
      r_byte_idx  <= 2'd0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_word_addr <= w_word_addr;
      r_word      <= w_word;
      r_last      <= w_last;
      r_byte_idx  <= w_byte_idx;
      r_cnt       <= w_cnt;
      r_ovf       <= w_ovf;
      r_ready     <= w_ready;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_word_addr = r_word_addr;
    w_word      = r_word;
    w_last      = r_last;
    w_byte_idx  = r_byte_idx;
    w_cnt       = r_cnt;
    w_ovf       = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_word_addr = bus.base_addr & c_align;
          w_cnt       = '0;
          w_ovf       = 1'b0;
          w_state     = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (bus.word_valid && r_ready) begin
          w_word     = bus.word_in;
          w_last     = bus.word_last;
          w_byte_idx = 2'd0;
          w_state    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_byte_idx == 2'd3) begin
          w_byte_idx  = 2'd0;
          w_word_addr = r_word_addr + c_word_step;
          w_cnt       = w_cnt_inc;
          if (r_last || (w_cnt_inc == c_max_words)) begin
            w_state = S_DONE;
            // Running out of room without a final word is the only error case.
            if (!r_last) begin
              w_ovf = 1'b1;
            end
          end else begin
            w_state = S_ACCEPT;
          end
        end else begin
          w_byte_idx = r_byte_idx + 2'd1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    w_ready = (w_state == S_ACCEPT);
    w_we    = (w_state == S_WRITE);
    w_busy  = (w_state != S_IDLE);
    w_done  = (w_state == S_DONE);
    w_addr  = {w_word_addr[ADDR_W-1:2], w_byte_idx};

    case (w_byte_idx)
      2'd0:    w_wdata = w_word[31:24];
      2'd1:    w_wdata = w_word[23:16];
      2'd2:    w_wdata = w_word[15:8];
      default: w_wdata = w_word[7:0];
    endcase
  end

  assign bus.word_ready   = r_ready;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.busy         = r_busy;
  assign bus.words_loaded = r_cnt;
  assign bus.load_done    = r_done;
  assign bus.overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Directed and randomized sessions against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

  localparam int ADDR_W    = 8;
  localparam int CNT_W     = 7;
  localparam int MAX_WORDS = 64;

  logic clk = 1'b0;
  logic reset_n;

  instr_mem_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  instr_mem_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [31:0] wq[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected byte stream: word i lands at aligned base + 4*i, MSB byte first.
  task automatic build_exp(input logic [7:0] base);
    logic [7:0] a0;
    exp_q.delete();
    a0 = base & 8'hFC;
    foreach (wq[i]) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({8'(a0 + 4 * i + k), 8'(wq[i] >> (24 - 8 * k))});
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check($sformatf("%s.nwrites", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.write%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic run_session(input string tag, input logic [7:0] base, input bit use_last,
                             input int gapmin, input int gapmax, input bit poke_start);
    int  n;
    int  cnt;
    int  gap;
    logic [7:0] a0;
    n  = wq.size();
    a0 = base & 8'hFC;
    build_exp(base);
    obs_q.delete();

    bus.base_addr = base;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.base_addr = 8'($urandom);
    check($sformatf("%s.busy_start", tag), 32'(bus.busy), 1);
    check($sformatf("%s.ready_start", tag), 32'(bus.word_ready), 1);
    check($sformatf("%s.cnt_start", tag), 32'(bus.words_loaded), 0);
    check($sformatf("%s.ovf_start", tag), 32'(bus.overflow), 0);

    for (int i = 0; i < n; i++) begin
      cnt = 0;
      while (bus.word_ready !== 1'b1 && cnt < 20) begin
        tick();
        cnt++;
      end
      check($sformatf("%s.ready_wait%0d", tag, i), 32'(bus.word_ready), 1);
      gap = int'($urandom_range(gapmax, gapmin));
      for (int g = 0; g < gap; g++) begin
        bus.word_valid = 1'b0;
        bus.word_in    = $urandom;
        tick();
        check($sformatf("%s.gap_we%0d", tag, i), 32'(bus.mem_we), 0);
      end
      bus.word_in    = wq[i];
      bus.word_last  = use_last && (i == n - 1);
      bus.word_valid = 1'b1;
      tick();
      bus.word_valid = 1'b0;
      bus.word_last  = 1'($urandom);
      bus.word_in    = $urandom;
      check($sformatf("%s.lat_we%0d", tag, i), 32'(bus.mem_we), 1);
      check($sformatf("%s.lat_ready%0d", tag, i), 32'(bus.word_ready), 0);
      check($sformatf("%s.lat_addr%0d", tag, i), 32'(bus.mem_addr), 32'(8'(a0 + 4 * i)));
      if (poke_start && i == 0) begin
        bus.base_addr = ~base;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
      end
    end

    cnt = 0;
    while (bus.load_done !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    check($sformatf("%s.done_seen", tag), 32'(bus.load_done), 1);
    if (!poke_start) check($sformatf("%s.done_lat", tag), 32'(cnt), 4);
    check($sformatf("%s.busy_done", tag), 32'(bus.busy), 1);
    check($sformatf("%s.cnt_done", tag), 32'(bus.words_loaded), 32'(n));
    check($sformatf("%s.ovf_done", tag), 32'(bus.overflow), 32'(!use_last && n == MAX_WORDS));
    tick();
    check($sformatf("%s.done_pulse", tag), 32'(bus.load_done), 0);
    check($sformatf("%s.busy_idle", tag), 32'(bus.busy), 0);
    check($sformatf("%s.ready_idle", tag), 32'(bus.word_ready), 0);
    check($sformatf("%s.cnt_hold", tag), 32'(bus.words_loaded), 32'(n));
    compare_writes(tag);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst.we", 32'(bus.mem_we), 0);
    check("rst.ready", 32'(bus.word_ready), 0);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.load_done), 0);
    check("rst.ovf", 32'(bus.overflow), 0);
    check("rst.cnt", 32'(bus.words_loaded), 0);
    check("rst.addr", 32'(bus.mem_addr), 0);
    check("rst.wdata", 32'(bus.mem_wdata), 0);
    reset_n = 1'b1;
    tick();
    check("rst.idle_busy", 32'(bus.busy), 0);

    // Single word with last, base 0x10.
    wq = '{32'h12345678};
    run_session("single", 8'h10, 1'b1, 0, 0, 1'b0);

    // Unaligned base and a 3-cycle source stall before the accept.
    wq = '{32'hCAFEF00D};
    run_session("unaligned", 8'h13, 1'b1, 3, 3, 1'b0);

    // Address wrap past the top of memory.
    wq = '{32'hAABBCCDD, 32'h01020304};
    run_session("wrap", 8'hFC, 1'b1, 0, 0, 1'b0);

    // start pulsed while a word is being written.
    wq = '{32'hDEADBEEF, 32'h0BADC0DE};
    run_session("poke", 8'h24, 1'b1, 0, 1, 1'b1);

    // Capacity reached without a final word.
    wq.delete();
    for (int i = 0; i < MAX_WORDS; i++) wq.push_back($urandom);
    run_session("overflow", 8'($urandom), 1'b0, 0, 0, 1'b0);
    bus.word_valid = 1'b1;
    bus.word_in    = $urandom;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ovf.idle_ready%0d", i), 32'(bus.word_ready), 0);
      check($sformatf("ovf.idle_we%0d", i), 32'(bus.mem_we), 0);
      check($sformatf("ovf.sticky%0d", i), 32'(bus.overflow), 1);
    end
    bus.word_valid = 1'b0;

    // Randomized sessions; the start checks also confirm overflow clears.
    for (int s = 0; s < 5; s++) begin
      wq.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) wq.push_back($urandom);
      run_session($sformatf("rand%0d", s), 8'($urandom), 1'b1, 0, 3, 1'b0);
    end

    // Asynchronous reset in the middle of a word write.
    obs_q.delete();
    bus.base_addr = 8'h40;
    bus.start     = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.word_in    = $urandom;
    bus.word_last  = 1'b1;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    tick();
    check("midrst.pre_we", 32'(bus.mem_we), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst.we", 32'(bus.mem_we), 0);
    check("midrst.ready", 32'(bus.word_ready), 0);
    check("midrst.busy", 32'(bus.busy), 0);
    check("midrst.done", 32'(bus.load_done), 0);
    check("midrst.cnt", 32'(bus.words_loaded), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    obs_q.delete();
    bus.word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midrst.idle_busy%0d", i), 32'(bus.busy), 0);
      check($sformatf("midrst.idle_ready%0d", i), 32'(bus.word_ready), 0);
    end
    bus.word_valid = 1'b0;
    check("midrst.no_writes", 32'(obs_q.size()), 0);

    // A fresh session after reset behaves normally.
    wq = '{32'h89ABCDEF};
    run_session("post_rst", 8'h80, 1'b1, 0, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
